// File: rtl/axis_testpattern_checker_if.sv
// axis_testpattern_checker_if: AXI-Stream tdata/tvalid/tready bundle between a pattern source and the checker
interface axis_testpattern_checker_if #(
    parameter int TDATA_WIDTH = 32
);
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    modport master (output tdata, output tvalid, input tready);
    modport slave (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_testpattern_checker.sv
// axis_testpattern_checker: AXI-Stream sink that locks onto a wrapping counter pattern and counts beats and mismatches
// Optional macro AXIS_TPCHECK_LASTERR_EN adds capture of the expected/received values of the last counted error.
module axis_testpattern_checker #(
    parameter int S00_AXIS_TDATA_WIDTH = 32,
    parameter int COUNTER_START        = 0,
    parameter int COUNTER_END          = 255,
    parameter int COUNTER_INCR         = 1,
    parameter int READY_DIVIDER        = 0,
    parameter int LOCK_THRESHOLD       = 4,
    parameter int LOSS_THRESHOLD       = 3,
    parameter int ERRCNT_WIDTH         = 16
) (
    input  logic                            s_axis_aclk,
    input  logic                            s_axis_areset,
    input  logic                            enable,
    input  logic                            clear,
    axis_testpattern_checker_if.slave       s_axis,
    output logic                            locked,
    output logic                            error_pulse,
    output logic [ERRCNT_WIDTH-1:0]         error_count,
    output logic [31:0]                     beat_count
`ifdef AXIS_TPCHECK_LASTERR_EN
    ,
    output logic [S00_AXIS_TDATA_WIDTH-1:0] last_err_expected,
    output logic [S00_AXIS_TDATA_WIDTH-1:0] last_err_received
`endif
);
    localparam int W       = S00_AXIS_TDATA_WIDTH;
    localparam int RUN_MAX = LOCK_THRESHOLD > LOSS_THRESHOLD ? LOCK_THRESHOLD : LOSS_THRESHOLD;
    localparam int RUN_W   = $clog2(RUN_MAX + 1);
    localparam int THR_W   = READY_DIVIDER > 0 ? $clog2(READY_DIVIDER + 1) : 1;
    localparam logic [W-1:0] START    = W'(COUNTER_START);
    localparam logic [W-1:0] SPAN     = W'(COUNTER_END - COUNTER_START);
    localparam logic [W-1:0] WRAP_AT  = W'(COUNTER_END - COUNTER_INCR + 1);
    localparam logic [W-1:0] WRAP_SUB = W'(COUNTER_END - COUNTER_START + 1 - COUNTER_INCR);
    localparam logic [W-1:0] INCR     = W'(COUNTER_INCR);

    typedef enum logic [1:0] {SEEK, ACQUIRE, LOCKED} state_t;

    state_t                  state_q;
    logic [W-1:0]            expected_q;
    logic [W-1:0]            expected_d;
    logic [RUN_W-1:0]        match_run_q;
    logic [RUN_W-1:0]        miss_run_q;
    logic [THR_W-1:0]        thr_q;
    logic                    locked_q;
    logic                    error_pulse_q;
    logic [ERRCNT_WIDTH-1:0] error_count_q;
    logic [31:0]             beat_count_q;
    logic                    acc;
    logic                    hit;
`ifdef AXIS_TPCHECK_LASTERR_EN
    logic [W-1:0]            last_exp_q;
    logic [W-1:0]            last_rcv_q;
    assign last_err_expected = last_exp_q;
    assign last_err_received = last_rcv_q;
`endif

    assign locked      = locked_q;
    assign error_pulse = error_pulse_q;
    assign error_count = error_count_q;
    assign beat_count  = beat_count_q;

    // Handshake, match test (value must equal expected and lie inside the pattern range) and resync target
    always_comb begin
        s_axis.tready = enable & (thr_q == '0) & ~s_axis_areset;
        acc           = s_axis.tvalid & s_axis.tready;
        hit           = (s_axis.tdata == expected_q) & ((s_axis.tdata - START) <= SPAN);
        expected_d    = (s_axis.tdata >= WRAP_AT) ? s_axis.tdata - WRAP_SUB : s_axis.tdata + INCR;
    end

    // Free-running throttle: ready only on the cycle the down-counter sits at zero
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset)
            thr_q <= '0;
        else
            thr_q <= (thr_q == '0) ? THR_W'(READY_DIVIDER) : thr_q - THR_W'(1);
    end

    // Lock FSM with registered status outputs and counters; clear overrides a same-cycle increment
    always_ff @(posedge s_axis_aclk) begin
        if (s_axis_areset) begin
            state_q       <= SEEK;
            expected_q    <= START;
            match_run_q   <= '0;
            miss_run_q    <= '0;
            locked_q      <= 1'b0;
            error_pulse_q <= 1'b0;
            error_count_q <= '0;
            beat_count_q  <= '0;
`ifdef AXIS_TPCHECK_LASTERR_EN
            last_exp_q    <= '0;
            last_rcv_q    <= '0;
`endif
        end else begin
            error_pulse_q <= 1'b0;
            if (acc) begin
                expected_q   <= expected_d;
                beat_count_q <= beat_count_q + 32'd1;
                case (state_q)
                    SEEK: begin
                        state_q     <= ACQUIRE;
                        match_run_q <= '0;
                    end
                    ACQUIRE: begin
                        if (hit) begin
                            match_run_q <= match_run_q + RUN_W'(1);
                            if (match_run_q + RUN_W'(1) == RUN_W'(LOCK_THRESHOLD)) begin
                                state_q    <= LOCKED;
                                locked_q   <= 1'b1;
                                miss_run_q <= '0;
                            end
                        end else begin
                            match_run_q <= '0;
                        end
                    end
                    LOCKED: begin
                        if (hit) begin
                            miss_run_q <= '0;
                        end else begin
                            error_count_q <= (&error_count_q) ? error_count_q : error_count_q + ERRCNT_WIDTH'(1);
                            error_pulse_q <= 1'b1;
                            miss_run_q    <= miss_run_q + RUN_W'(1);
`ifdef AXIS_TPCHECK_LASTERR_EN
                            last_exp_q    <= expected_q;
                            last_rcv_q    <= s_axis.tdata;
`endif
                            if (miss_run_q + RUN_W'(1) == RUN_W'(LOSS_THRESHOLD)) begin
                                state_q  <= SEEK;
                                locked_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= SEEK;
                endcase
            end
            if (clear) begin
                error_count_q <= '0;
                beat_count_q  <= '0;
`ifdef AXIS_TPCHECK_LASTERR_EN
                last_exp_q    <= '0;
                last_rcv_q    <= '0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_axis_testpattern_checker.sv
// tb_axis_testpattern_checker: randomized and directed checks of two checker configurations against a beat-level model
module tb_axis_testpattern_checker;
    typedef struct packed {
        int          st;
        int          mrun;
        int          xrun;
        logic [31:0] exp;
        bit          locked;
        bit          pulse;
        int          ec;
        logic [31:0] bc;
        int          ph;
        logic [31:0] le_e;
        logic [31:0] le_r;
    } mdl_t;

    typedef struct packed {
        longint s;
        longint e;
        longint i;
        int     div;
        int     lk;
        int     ls;
        int     ecmax;
    } cfg_t;

    localparam int S_SEEK = 0, S_ACQ = 1, S_LOCK = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en1 = 1'b0, clr1 = 1'b0, v1 = 1'b0;
    logic        en2 = 1'b0, clr2 = 1'b0, v2 = 1'b0;
    logic [31:0] d1 = '0, d2 = '0;
    logic        lk1, lk2, pl1, pl2;
    logic [15:0] ec1;
    logic [3:0]  ec2;
    logic [31:0] bc1, bc2;
`ifdef AXIS_TPCHECK_LASTERR_EN
    logic [31:0] le1_e, le1_r, le2_e, le2_r;
`endif
    int          n_chk = 0;
    int          n_pass = 0;
    bit          acc1, acc2;
    logic [31:0] p1, p2;
    mdl_t        m1, m2;
    cfg_t        c1, c2;

    always #5 clk = ~clk;

    axis_testpattern_checker_if #(.TDATA_WIDTH(32)) ax1 ();
    axis_testpattern_checker_if #(.TDATA_WIDTH(32)) ax2 ();
    assign ax1.tdata  = d1;
    assign ax1.tvalid = v1;
    assign ax2.tdata  = d2;
    assign ax2.tvalid = v2;

    axis_testpattern_checker dut1 (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .enable        (en1),
        .clear         (clr1),
        .s_axis        (ax1),
        .locked        (lk1),
        .error_pulse   (pl1),
        .error_count   (ec1),
        .beat_count    (bc1)
`ifdef AXIS_TPCHECK_LASTERR_EN
        ,
        .last_err_expected (le1_e),
        .last_err_received (le1_r)
`endif
    );

    axis_testpattern_checker #(
        .S00_AXIS_TDATA_WIDTH (32),
        .COUNTER_START        (3),
        .COUNTER_END          (10),
        .COUNTER_INCR         (3),
        .READY_DIVIDER        (2),
        .LOCK_THRESHOLD       (4),
        .LOSS_THRESHOLD       (3),
        .ERRCNT_WIDTH         (4)
    ) dut2 (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .enable        (en2),
        .clear         (clr2),
        .s_axis        (ax2),
        .locked        (lk2),
        .error_pulse   (pl2),
        .error_count   (ec2),
        .beat_count    (bc2)
`ifdef AXIS_TPCHECK_LASTERR_EN
        ,
        .last_err_expected (le2_e),
        .last_err_received (le2_r)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    function automatic logic [31:0] nxt(cfg_t c, logic [31:0] x);
        longint t;
        t = longint'(x);
        t = (t >= c.e - c.i + 1) ? t + c.i - (c.e - c.s) - 1 : t + c.i;
        return t[31:0];
    endfunction

    function automatic mdl_t mreset(cfg_t c);
        mdl_t m;
        m = '0;
        m.exp = 32'(c.s);
        return m;
    endfunction

    function automatic bit mready(mdl_t m, cfg_t c, bit r, bit en);
        return en && !r && (m.ph % (c.div + 1) == 0);
    endfunction

    function automatic mdl_t mstep(mdl_t m, cfg_t c, bit r, bit en, bit clr, bit v, logic [31:0] d);
        mdl_t n;
        bit   hit;
        if (r) return mreset(c);
        n = m;
        n.ph = m.ph + 1;
        n.pulse = 0;
        if (v && mready(m, c, r, en)) begin
            hit = (longint'(d) >= c.s) && (longint'(d) <= c.e) && (d == m.exp);
            n.exp = nxt(c, d);
            n.bc = m.bc + 1;
            if (m.st == S_SEEK) begin
                n.st = S_ACQ;
                n.mrun = 0;
            end else if (m.st == S_ACQ) begin
                n.mrun = hit ? m.mrun + 1 : 0;
                if (n.mrun == c.lk) begin
                    n.st = S_LOCK;
                    n.locked = 1;
                    n.xrun = 0;
                end
            end else if (hit) begin
                n.xrun = 0;
            end else begin
                n.ec = (m.ec == c.ecmax) ? m.ec : m.ec + 1;
                n.pulse = 1;
                n.xrun = m.xrun + 1;
                n.le_e = m.exp;
                n.le_r = d;
                if (n.xrun == c.ls) begin
                    n.st = S_SEEK;
                    n.locked = 0;
                end
            end
        end
        if (clr) begin
            n.ec = 0;
            n.bc = 0;
            n.le_e = 0;
            n.le_r = 0;
        end
        return n;
    endfunction

    task automatic tick();
        bit r1, r2;
        #1;
        r1 = mready(m1, c1, rst, en1);
        r2 = mready(m2, c2, rst, en2);
        check("tready1", ax1.tready, r1);
        check("tready2", ax2.tready, r2);
        acc1 = v1 && r1;
        acc2 = v2 && r2;
        @(posedge clk);
        m1 = mstep(m1, c1, rst, en1, clr1, v1, d1);
        m2 = mstep(m2, c2, rst, en2, clr2, v2, d2);
        #1;
        check("locked1", lk1, m1.locked);
        check("pulse1", pl1, m1.pulse);
        check("errcnt1", ec1, m1.ec);
        check("beats1", bc1, m1.bc);
        check("locked2", lk2, m2.locked);
        check("pulse2", pl2, m2.pulse);
        check("errcnt2", ec2, m2.ec);
        check("beats2", bc2, m2.bc);
`ifdef AXIS_TPCHECK_LASTERR_EN
        check("lasterr_exp1", le1_e, m1.le_e);
        check("lasterr_rcv1", le1_r, m1.le_r);
        check("lasterr_exp2", le2_e, m2.le_e);
        check("lasterr_rcv2", le2_r, m2.le_r);
`endif
    endtask

    task automatic send1(input logic [31:0] d);
        v1 = 1;
        d1 = d;
        tick();
        check("send1_acc", acc1, 1);
        v1 = 0;
    endtask

    task automatic send2(input logic [31:0] d);
        v2 = 1;
        d2 = d;
        for (int t = 0; t < 8; t++) begin
            tick();
            if (acc2) break;
        end
        check("send2_acc", acc2, 1);
        v2 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int q[$];
        int ph2[] = '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 99, 100, 101};
        logic [31:0] bad;
        c1 = '{s: 0, e: 255, i: 1, div: 0, lk: 4, ls: 3, ecmax: 16'hFFFF};
        c2 = '{s: 3, e: 10, i: 3, div: 2, lk: 4, ls: 3, ecmax: 15};
        m1 = mreset(c1);
        m2 = mreset(c2);
        en1 = 1;
        en2 = 1;
        repeat (3) tick();
        check("rst_locked1", lk1, 0);
        check("rst_beats1", bc1, 0);
        rst = 0;
        p2 = 3;
        // count 0..255,0,1 on dut1 while dut2 runs its throttled 3,6,9,4,... pattern
        for (int i = 0; i < 258; i++) begin
            v1 = 1;
            d1 = i % 256;
            v2 = 1;
            d2 = p2;
            tick();
            if (acc2) p2 = nxt(c2, p2);
            if (i == 3) check("t1_not_yet_locked", lk1, 0);
            if (i == 4) check("t1_locked_after_5th", lk1, 1);
            if (i == 29) check("t4_beats_in_30", bc2, 10);
        end
        check("t1_errcnt", ec1, 0);
        check("t5_locked2", lk2, 1);
        check("t5_errcnt2", ec2, 0);
        // single error with resync; dut2 disabled meanwhile
        en2 = 0;
        foreach (ph2[k]) begin
            v1 = 1;
            d1 = ph2[k];
            tick();
            check("t4_ready_disabled", ax2.tready, 0);
            if (ph2[k] == 99) check("t2_pulse_after_99", pl1, 1);
            if (ph2[k] == 100) check("t2_pulse_gone", pl1, 0);
        end
        check("t2_errcnt", ec1, 1);
        check("t2_locked", lk1, 1);
        check("t4_beats_held", bc2, 86);
`ifdef AXIS_TPCHECK_LASTERR_EN
        check("t6_lasterr_exp", le1_e, 12);
        check("t6_lasterr_rcv", le1_r, 99);
`endif
        // lock loss after three consecutive mismatches, then re-lock
        v1 = 0;
        clr1 = 1;
        tick();
        clr1 = 0;
        check("t3_cleared", ec1, 0);
        for (int x = 102; x < 256; x++) q.push_back(x);
        for (int x = 0; x < 7; x++) q.push_back(x);
        q.push_back(50);
        q.push_back(9);
        q.push_back(200);
        foreach (q[k]) send1(q[k]);
        check("t3_errcnt", ec1, 3);
        check("t3_lost", lk1, 0);
        for (int x = 201; x <= 204; x++) send1(x);
        check("t3_not_relocked", lk1, 0);
        send1(205);
        check("t3_relocked", lk1, 1);
        // saturation on the 4-bit counter of dut2
        en2 = 1;
        for (int k = 0; k < 20; k++) begin
            bad = (p2 == 3) ? 4 : 3;
            send2(bad);
            p2 = nxt(c2, bad);
            send2(p2);
            p2 = nxt(c2, p2);
        end
        check("t6_saturated", ec2, 15);
        check("t6_still_locked", lk2, 1);
        // clear in the same cycle as a counted error
        v1 = 1;
        d1 = 99;
        clr1 = 1;
        tick();
        clr1 = 0;
        v1 = 0;
        check("t6_clear_beats_error", ec1, 0);
        check("t6_clear_beats_count", bc1, 0);
        p1 = 100;
        // randomized traffic on both instances
        for (int k = 0; k < 1500; k++) begin
            v1 = $urandom_range(0, 3) != 0;
            en1 = $urandom_range(0, 7) != 0;
            clr1 = $urandom_range(0, 63) == 0;
            d1 = ($urandom_range(0, 9) != 0) ? p1 : 32'($urandom_range(0, 300));
            v2 = $urandom_range(0, 3) != 0;
            en2 = $urandom_range(0, 7) != 0;
            clr2 = $urandom_range(0, 63) == 0;
            d2 = ($urandom_range(0, 9) != 0) ? p2 : 32'($urandom_range(0, 15));
            tick();
            if (acc1) p1 = nxt(c1, d1);
            if (acc2) p2 = nxt(c2, d2);
        end
        clr1 = 0;
        clr2 = 0;
        en1 = 1;
        en2 = 1;
        // reset in the middle of a stream
        v1 = 1;
        d1 = p1;
        v2 = 1;
        d2 = p2;
        rst = 1;
        tick();
        check("t6_rst_locked1", lk1, 0);
        check("t6_rst_errcnt1", ec1, 0);
        check("t6_rst_beats1", bc1, 0);
        check("t6_rst_pulse1", pl1, 0);
        check("t6_rst_locked2", lk2, 0);
        check("t6_rst_beats2", bc2, 0);
        rst = 0;
        v2 = 0;
        for (int x = 0; x < 5; x++) send1(x);
        check("t6_relock_after_rst", lk1, 1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
